voice_osc_bank: RTL

- Downstream consumer of the 16-note chord generator.
- Converts the 16 note numbers it receives into 16 free-running sawtooth oscillators.
- Time-multiplexes one phase accumulator across all voices and mixes them into one 12-bit unsigned sample per sample tick.
- The output feeds the audio DAC/PWM stage.

---
 rtl/voice_osc_bank_if.sv | 30 +++
 rtl/voice_osc_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/voice_osc_bank_if.sv
// Tick/notes in, mixed sample and status out, between the voice oscillator
// bank and its neighbours (chord generator upstream, DAC/PWM downstream).
interface voice_osc_bank_if #(
    parameter int NVOICE = 16
);
    logic                  sample_tick;
    logic [7*NVOICE-1:0]   notes;
    logic [11:0]           sample_out;
    logic                  sample_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output sample_tick,
        output notes,
        input  sample_out,
        input  sample_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample_tick,
        input  notes,
        output sample_out,
        output sample_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/voice_osc_bank.sv
// Sixteen sawtooth oscillators sharing one phase adder: each sample tick
// snapshots the notes, steps every voice once and sums their top phase bytes.
module voice_osc_bank #(
    parameter int PHASE_W = 24,
    parameter int NVOICE  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    voice_osc_bank_if.slave  bus
);

    localparam int IDX_W  = $clog2(NVOICE);
    localparam int MIX_W  = 12;
    localparam int NOTE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         v_q, v_d;
    logic [PHASE_W-1:0]       phase_q [NVOICE];
    logic [PHASE_W-1:0]       phase_d [NVOICE];
    logic [MIX_W-1:0]         acc_q, acc_d;
    logic [MIX_W-1:0]         out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic [NOTE_W*NVOICE-1:0] snap_q, snap_d;

    logic [NOTE_W-1:0]        cur_note;
    logic [NOTE_W-1:0]        rem;
    logic [3:0]               octave;
    logic [3:0]               semitone;
    logic [PHASE_W-1:0]       base;
    logic [PHASE_W-1:0]       inc;
    logic [PHASE_W-1:0]       phase_next;

    assign cur_note = snap_q[NOTE_W*v_q +: NOTE_W];

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value (rem here); clocked blocks use '<=' only.
    always_comb begin
        rem    = cur_note;
        octave = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (rem >= 7'd12) begin
                rem    = rem - 7'd12;
                octave = octave + 4'd1;
            end
        end
        semitone = rem[3:0];
    end

    // Increments for MIDI octave 10; lower octaves are right shifts of these.
    always_comb begin
        base = '0;
        case (semitone)
            4'd0:    base = PHASE_W'(2926230);
            4'd1:    base = PHASE_W'(3100233);
            4'd2:    base = PHASE_W'(3284581);
            4'd3:    base = PHASE_W'(3479893);
            4'd4:    base = PHASE_W'(3686818);
            4'd5:    base = PHASE_W'(3906048);
            4'd6:    base = PHASE_W'(4138314);
            4'd7:    base = PHASE_W'(4384391);
            4'd8:    base = PHASE_W'(4645100);
            4'd9:    base = PHASE_W'(4921312);
            4'd10:   base = PHASE_W'(5213948);
            4'd11:   base = PHASE_W'(5523985);
            default: base = '0;
        endcase
    end

    assign inc        = base >> (4'd10 - octave);
    assign phase_next = phase_q[v_q] + inc;

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        snap_d    = snap_q;

        case (state_q)
            IDLE: begin
                if (bus.sample_tick) begin
                    snap_d  = bus.notes;
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (bus.sample_tick) begin
                    overrun_d = 1'b1;
                end
                if (cur_note == '0) begin
                    phase_d[v_q] = '0;
                end else begin
                    phase_d[v_q] = phase_next;
                    acc_d        = acc_q + MIX_W'(phase_next[PHASE_W-1 -: 8]);
                end
                v_d = v_q + 1'b1;
                if (v_q == IDX_W'(NVOICE - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.sample_tick) begin
                    overrun_d = 1'b1;
                end
                out_d   = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the phase array is a register file that must restart from zero
    // after reset, so every entry is cleared here rather than left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            v_q       <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            snap_q    <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            snap_q    <= snap_d;
            for (int i = 0; i < NVOICE; i++) begin
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.overrun      = overrun_q;

endmodule
